// File: rtl/canvas_write_arbiter.sv
// Single write port of the canvas pixel store: round-robin between brush writes
// and a raster clear engine, optionally confined to vertical blanking.
module canvas_write_arbiter #(
   parameter int COLS        = 40,
   parameter int ROWS        = 30,
   parameter int CW          = 6,
   parameter int GATE_VBLANK = 1,
   parameter int XW          = $clog2(COLS),
   parameter int YW          = $clog2(ROWS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vblank,
   input  logic          brush_req,
   input  logic [XW-1:0] brush_x,
   input  logic [YW-1:0] brush_y,
   input  logic [CW-1:0] brush_color,
   output logic          brush_gnt,
   input  logic          clr_start,
   input  logic [CW-1:0] clr_color,
   output logic          clr_busy,
   output logic          clr_done,
   output logic          wr_en,
   output logic [XW-1:0] wr_x,
   output logic [YW-1:0] wr_y,
   output logic [CW-1:0] wr_data
);

   typedef enum logic {IDLE, CLEAR} state_t;
   typedef enum logic {SRC_BRUSH, SRC_CLEAR} src_t;

   typedef struct packed {
      logic          en;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [CW-1:0] data;
   } wr_t;

   state_t        state, state_n;
   src_t          rr_last, rr_last_n;
   logic [XW-1:0] cx, cx_n;
   logic [YW-1:0] cy, cy_n;
   logic [CW-1:0] col, col_n;

   logic write_ok, brush_elig, clr_elig;
   logic gnt_b, gnt_c, last_cell, in_range;
   logic done_n, busy_n;
   wr_t  wr_q, wr_d;

   assign write_ok   = vblank | (GATE_VBLANK == 0);
   // brush_gnt is still high the edge after a grant, so a held request waits one cycle
   assign brush_elig = brush_req & ~brush_gnt;
   assign clr_elig   = (state == CLEAR);
   assign last_cell  = (cx == XW'(COLS - 1)) && (cy == YW'(ROWS - 1));
   assign in_range   = ({1'b0, brush_x} < (XW + 1)'(COLS)) &&
                       ({1'b0, brush_y} < (YW + 1)'(ROWS));

   always_comb begin
      gnt_b     = 1'b0;
      gnt_c     = 1'b0;
      state_n   = state;
      rr_last_n = rr_last;
      cx_n      = cx;
      cy_n      = cy;
      col_n     = col;
      done_n    = 1'b0;
      wr_d      = '{en: 1'b0, x: wr_q.x, y: wr_q.y, data: wr_q.data};

      if (write_ok) begin
         if (brush_elig && (!clr_elig || rr_last == SRC_CLEAR)) gnt_b = 1'b1;
         else if (clr_elig)                                     gnt_c = 1'b1;
      end

      if (gnt_b) begin
         rr_last_n = SRC_BRUSH;
         wr_d      = '{en: in_range, x: brush_x, y: brush_y, data: brush_color};
      end else if (gnt_c) begin
         rr_last_n = SRC_CLEAR;
         wr_d      = '{en: 1'b1, x: cx, y: cy, data: col};
         if (last_cell) begin
            done_n  = 1'b1;
            state_n = IDLE;
            cx_n    = '0;
            cy_n    = '0;
         end else if (cx == XW'(COLS - 1)) begin
            cx_n = '0;
            cy_n = cy + 1'b1;
         end else begin
            cx_n = cx + 1'b1;
         end
      end

      if (state == IDLE && clr_start) begin
         state_n = CLEAR;
         col_n   = clr_color;
      end

      // busy covers the clr_done cycle and drops one cycle later
      busy_n = (state_n == CLEAR) | done_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_last   <= SRC_BRUSH;
         cx        <= '0;
         cy        <= '0;
         col       <= '0;
         wr_q      <= '0;
         brush_gnt <= 1'b0;
         clr_done  <= 1'b0;
         clr_busy  <= 1'b0;
      end else begin
         state     <= state_n;
         rr_last   <= rr_last_n;
         cx        <= cx_n;
         cy        <= cy_n;
         col       <= col_n;
         wr_q      <= wr_d;
         brush_gnt <= gnt_b;
         clr_done  <= done_n;
         clr_busy  <= busy_n;
      end
   end

   assign wr_en   = wr_q.en;
   assign wr_x    = wr_q.x;
   assign wr_y    = wr_q.y;
   assign wr_data = wr_q.data;

endmodule

// File: tb/tb_canvas_write_arbiter.sv
// Directed and randomized checks of the canvas write arbiter against a
// cell-index reference model.
module tb_canvas_write_arbiter;
   localparam int COLS = 40, ROWS = 30, CW = 6, XW = 6, YW = 5;
   localparam int CELLS = COLS * ROWS;

   logic          clk = 0, rst_n = 0, vblank = 0;
   logic          brush_req = 0, clr_start = 0;
   logic [XW-1:0] brush_x = 0;
   logic [YW-1:0] brush_y = 0;
   logic [CW-1:0] brush_color = 0, clr_color = 0;
   logic          brush_gnt, clr_busy, clr_done, wr_en;
   logic [XW-1:0] wr_x;
   logic [YW-1:0] wr_y;
   logic [CW-1:0] wr_data;

   canvas_write_arbiter #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .GATE_VBLANK(1)) dut (
      .clk(clk), .rst_n(rst_n), .vblank(vblank),
      .brush_req(brush_req), .brush_x(brush_x), .brush_y(brush_y),
      .brush_color(brush_color), .brush_gnt(brush_gnt),
      .clr_start(clr_start), .clr_color(clr_color),
      .clr_busy(clr_busy), .clr_done(clr_done),
      .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data));

   always #5 clk = ~clk;

   int tests = 0, failed = 0;

   // reference model: clear progress as a linear cell index
   bit            m_clr, m_last_clr;
   int            m_n;
   logic [CW-1:0] m_col;
   logic          e_gnt, e_wen, e_done, e_busy;
   logic [XW-1:0] e_x;
   logic [YW-1:0] e_y;
   logic [CW-1:0] e_d;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_clr = 0; m_last_clr = 0; m_n = 0; m_col = 0;
      e_gnt = 0; e_wen = 0; e_done = 0; e_busy = 0; e_x = 0; e_y = 0; e_d = 0;
   endtask

   task automatic model_step();
      bit ok, want_b, gb, gc, was_clr;
      ok      = vblank;
      want_b  = brush_req && !e_gnt;
      was_clr = m_clr;
      gb = ok && want_b && (!m_clr || m_last_clr);
      gc = ok && m_clr && !gb;
      e_gnt = gb; e_wen = 0; e_done = 0;
      if (gb) begin
         m_last_clr = 0;
         e_wen = (brush_x < COLS) && (brush_y < ROWS);
         e_x = brush_x; e_y = brush_y; e_d = brush_color;
      end else if (gc) begin
         m_last_clr = 1;
         e_wen = 1;
         e_x = XW'(m_n % COLS); e_y = YW'(m_n / COLS); e_d = m_col;
         m_n++;
         if (m_n == CELLS) begin e_done = 1; m_clr = 0; m_n = 0; end
      end
      if (!was_clr && clr_start) begin m_clr = 1; m_col = clr_color; end
      e_busy = m_clr || e_done;
   endtask

   function automatic logic [31:0] pack_out();
      return {11'b0, brush_gnt, wr_en, wr_x, wr_y, wr_data, clr_done, clr_busy};
   endfunction

   function automatic logic [31:0] pack_exp();
      return {11'b0, e_gnt, e_wen, e_x, e_y, e_d, e_done, e_busy};
   endfunction

   // called just after a negedge with inputs applied; returns at the next negedge
   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      clr_start = 0;
      chk("outputs", pack_out(), pack_exp());
   endtask

   task automatic set_brush(input int x, input int y, input int c);
      brush_req = 1; brush_x = XW'(x); brush_y = YW'(y); brush_color = CW'(c);
   endtask

   int wcnt, dcnt, done_x, done_y, done_d, wait_c, max_wait, bcnt;
   bit seen;

   initial begin
      model_reset();
      #2;
      chk("reset_outputs", pack_out(), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("idle_after_reset", pack_out(), pack_exp());

      // single brush write
      vblank = 1;
      set_brush(12, 7, 'h2A);
      cycle();
      chk("brush_gnt", brush_gnt, 1);
      chk("brush_wr", {wr_en, wr_x, wr_y, wr_data}, {1'b1, 6'd12, 5'd7, 6'h2A});
      brush_req = 0;
      cycle();
      chk("brush_no_second", {wr_en, brush_gnt}, 2'b00);
      chk("brush_hold_xy", {wr_x, wr_y, wr_data}, {6'd12, 5'd7, 6'h2A});

      // full clear without contention
      clr_color = 'h2D; clr_start = 1;
      cycle();
      chk("busy_rise", clr_busy, 1);
      wcnt = 0; dcnt = 0;
      for (int i = 0; i < CELLS + 5; i++) begin
         cycle();
         if (wr_en) wcnt++;
         if (clr_done) begin dcnt++; done_x = wr_x; done_y = wr_y; done_d = wr_data; end
      end
      chk("clear_writes", wcnt, CELLS);
      chk("clear_done_cnt", dcnt, 1);
      chk("clear_done_cell", {done_x[7:0], done_y[7:0], done_d[7:0]}, {8'd39, 8'd29, 8'h2D});
      chk("busy_fall", clr_busy, 0);

      // clear contending with a continuously re-asserted brush
      clr_color = 'h15; clr_start = 1;
      set_brush(3, 4, 'h3F);
      seen = 0; max_wait = 0; wait_c = 0; bcnt = 0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         cycle();
         if (brush_gnt) begin bcnt++; wait_c = 0; end
         else begin wait_c++; if (wait_c > max_wait) max_wait = wait_c; end
         if (clr_done) seen = 1;
      end
      chk("contend_done", seen, 1);
      chk("contend_brush_wait", max_wait <= 2, 1);
      chk("contend_brush_cnt", bcnt >= CELLS - 1, 1);
      brush_req = 0;
      cycle(); cycle();

      // vblank gating
      vblank = 0;
      set_brush(20, 10, 'h01);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("gated_no_grant", {brush_gnt, wr_en}, 2'b00);
      end
      vblank = 1;
      cycle();
      chk("ungated_grant", {brush_gnt, wr_en, wr_x, wr_y}, {1'b1, 1'b1, 6'd20, 5'd10});
      brush_req = 0;

      // out-of-range brush is consumed without a write
      cycle();
      set_brush(40, 2, 'h03);
      cycle();
      chk("oor_gnt", {brush_gnt, wr_en}, 2'b10);
      brush_req = 0;

      // clr_start while busy is ignored, colour not re-latched
      clr_color = 'h0A; clr_start = 1;
      cycle();
      for (int i = 0; i < 10; i++) cycle();
      clr_color = 'h33; clr_start = 1;
      seen = 0;
      for (int i = 0; i < CELLS + 20 && !seen; i++) begin
         cycle();
         if (clr_done) begin seen = 1; done_d = wr_data; end
      end
      chk("restart_ignored_done", seen, 1);
      chk("restart_ignored_color", done_d[5:0], 6'h0A);
      cycle();

      // async reset in the middle of a clear
      clr_color = 'h11; clr_start = 1;
      seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         cycle();
         if (wr_en && wr_x == 5 && wr_y == 3) seen = 1;
      end
      chk("reached_5_3", seen, 1);
      rst_n = 0;
      #1;
      chk("async_reset_outputs", pack_out(), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 5; i++) cycle();
      clr_color = 'h22; clr_start = 1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         cycle();
         if (wr_en) begin seen = 1; chk("restart_origin", {wr_x, wr_y, wr_data}, {6'd0, 5'd0, 6'h22}); end
      end
      chk("restart_seen", seen, 1);

      // randomized traffic
      for (int i = 0; i < 6000; i++) begin
         vblank = ($urandom_range(0, 3) != 0);
         if (brush_req && brush_gnt) begin
            brush_req = $urandom_range(0, 1);
            if (brush_req) set_brush($urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 63));
         end else if (!brush_req && $urandom_range(0, 2) == 0) begin
            set_brush($urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 63));
         end
         if ($urandom_range(0, 299) == 0) begin
            clr_start = 1; clr_color = CW'($urandom_range(0, 63));
         end
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
